d_reg_scoreboard: RTL and testbench
===================================

Name: d_reg_scoreboard

Overview:
Read-side hazard tracker for the general register file in the 5-stage MIPS pipeline.
- Sits in the D stage beside the register file.
- Records every in-flight writer issued from D and retires it when the W-stage write port commits.
- Asserts stall when a D-stage source operand cannot yet be obtained from either the file or a forwarding path.

Parameters:
CNT_W, 2, width of per-register in-flight writer counter (max 2^CNT_W-1 outstanding writers per register)
TNEW_W, 2, width of per-register "cycles until result forwardable" countdown

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
issue_valid  input  1  D-stage instruction wants to advance to E this cycle
rs_addr  input  5  rs source register number
rt_addr  input  5  rt source register number
rs_tuse  input  TNEW_W  cycles until rs value is consumed (0 = needed in D)
rt_tuse  input  TNEW_W  cycles until rt value is consumed
rs_used  input  1  instruction reads rs
rt_used  input  1  instruction reads rt
dst_we  input  1  instruction writes a register
dst_addr  input  5  destination register number
dst_tnew  input  TNEW_W  cycles from leaving D until result is forwardable
wb_we  input  1  register-file write enable (W stage)
wb_addr  input  5  register-file write address (W stage)
stall  output  1  hold F/D, bubble into E
stall_rs  output  1  stall caused by rs
stall_rt  output  1  stall caused by rt
pending_mask  output  32  bit i = register i has at least one in-flight writer

Behaviour:
- Per register i (1..31), state is cnt[i] (CNT_W bits) and tnew[i] (TNEW_W bits). Register 0 is never tracked; its cnt and tnew are held at 0.
- Reset: all cnt and tnew are cleared at the clock edge where reset=1. All outputs are 0 in the cycle after reset.
- pending_mask[i] = (cnt[i] != 0).
- stall_rs = rs_used && rs_addr!=0 && cnt[rs_addr]!=0 && tnew[rs_addr] > rs_tuse. stall_rt is symmetric.
- Structural stall: stall_full = dst_we && dst_addr!=0 && cnt[dst_addr] is at its maximum value.
- stall = stall_rs | stall_rt | stall_full. All three are combinational from current state and inputs, with zero latency.
- fire = issue_valid && !stall.
- Each posedge, with reset=0:
  - All nonzero tnew[i] decrement by 1, saturating at 0.
  - If fire && dst_we && dst_addr!=0: cnt[dst_addr]++ and tnew[dst_addr] <= dst_tnew. The youngest writer overrides; the load takes priority over the decrement.
  - If wb_we && wb_addr!=0 && cnt[wb_addr]!=0: cnt[wb_addr]--.
  - Issue and writeback to the same register in the same cycle: cnt unchanged, tnew reloaded.
  - wb_we to a register with cnt==0: ignored, no underflow.
- Reset mid-operation: all in-flight state is discarded, with no retire events.
- The block never stalls on a register whose only writers have tnew==0; the forwarding network supplies those values.

Optional Feature:
SB_TRACE_EN
- Defined: on each posedge where stall=1 && issue_valid=1 && reset=0, print "%d@stall rs=%d rt=%d" with $time, rs_addr, rt_addr.
- Not defined: no $display and no extra logic. Functional behaviour is identical either way.

Decomposition:
- Shared package sb_pkg holds:
  - TNEW_W/CNT_W defaults
  - Tuse/Tnew encoding constants: T0, T1, T2
  - Constant REG_ZERO = 5'd0
- One natural sub-module: sb_reg_entry, one cnt/tnew slot instantiated 31 times via generate. Its inputs are inc, dec, load value and tick; its outputs are pending and tnew.

Test Plan:
- Reset, then issue lw $8 (dst_tnew=2) and next cycle add reading $8 (rs_tuse=1) -> stall=1 for exactly 1 cycle, then fire. pending_mask[8]=1 until wb_we with wb_addr=8, then 0.
- Issue addu $9 (tnew=1), then beq reading $9 (rs_tuse=0) -> stall_rs=1 for 1 cycle. With rs_tuse=1 instead -> no stall.
- Write to $0 (dst_we=1, dst_addr=0), then read $0 with tuse=0 -> stall never asserted; pending_mask stays 0.
- CNT_W=2: three back-to-back writers to $5 with no writeback -> fourth writer gets stall=1 via stall_full. One wb_addr=5 pulse -> next cycle fire, cnt back to 3.
- Same cycle: fire with dst=$7 and wb_we with wb_addr=7 while cnt[7]=1 -> cnt[7]=1, tnew[7]=dst_tnew. Spurious wb to $10 with cnt=0 -> cnt stays 0.
- Reset asserted while cnt[3]=2 and tnew[3]=2 -> next cycle pending_mask=0, stall=0 for a read of $3 with tuse=0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and constants for the D-stage register scoreboard.
package sb_pkg;
  localparam int CNT_W_DEF  = 2;
  localparam int TNEW_W_DEF = 2;

  // Tuse / Tnew encodings (cycles)
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_reg_entry.sv
// One scoreboard slot: in-flight writer count plus forwardability countdown.
module sb_reg_entry
  import sb_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TNEW_W = TNEW_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic [TNEW_W-1:0] load,
  input  logic              tick,
  output logic              pending,
  output logic              full,
  output logic [TNEW_W-1:0] tnew
);
  logic [CNT_W-1:0] cnt;
  logic             dec_eff;

  // a retire with nothing outstanding is dropped so the count never wraps
  assign dec_eff = dec && (cnt != '0);
  assign pending = (cnt != '0);
  assign full    = &cnt;

  // writer count: issue and retire in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (inc && !dec_eff) cnt <= cnt + 1'b1;
    else if (!inc && dec_eff) cnt <= cnt - 1'b1;
  end

  // countdown: the youngest writer reloads, otherwise saturating decrement
  always_ff @(posedge clk) begin
    if (reset)                     tnew <= '0;
    else if (inc)                  tnew <= load;
    else if (tick && tnew != '0)   tnew <= tnew - 1'b1;
  end
endmodule

// File: rtl/d_reg_scoreboard.sv
// D-stage read-hazard scoreboard for the GPR file.
// Optional build macro SB_TRACE_EN prints a trace line for each stalled issue.
module d_reg_scoreboard
  import sb_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TNEW_W = TNEW_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [TNEW_W-1:0] rs_tuse,
  input  logic [TNEW_W-1:0] rt_tuse,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              dst_we,
  input  logic [4:0]        dst_addr,
  input  logic [TNEW_W-1:0] dst_tnew,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  output logic              stall,
  output logic              stall_rs,
  output logic              stall_rt,
  output logic [31:0]       pending_mask
);
  logic [31:0]             full_vec;
  logic [31:0][TNEW_W-1:0] tnew_vec;
  logic                    stall_full;
  logic                    fire;

  // $0 is hardwired: never pending, never full
  assign pending_mask[0] = 1'b0;
  assign full_vec[0]     = 1'b0;
  assign tnew_vec[0]     = '0;

  for (genvar i = 1; i < 32; i++) begin : g_ent
    sb_reg_entry #(.CNT_W(CNT_W), .TNEW_W(TNEW_W)) u_ent (
      .clk     (clk),
      .reset   (reset),
      .inc     (fire && dst_we && (dst_addr == 5'(i))),
      .dec     (wb_we && (wb_addr == 5'(i))),
      .load    (dst_tnew),
      .tick    (1'b1),
      .pending (pending_mask[i]),
      .full    (full_vec[i]),
      .tnew    (tnew_vec[i])
    );
  end

  // a source stalls only while its newest producer is not yet forwardable in time
  assign stall_rs = rs_used && (rs_addr != REG_ZERO) && pending_mask[rs_addr] &&
                    (tnew_vec[rs_addr] > rs_tuse);
  assign stall_rt = rt_used && (rt_addr != REG_ZERO) && pending_mask[rt_addr] &&
                    (tnew_vec[rt_addr] > rt_tuse);
  assign stall_full = dst_we && (dst_addr != REG_ZERO) && full_vec[dst_addr];
  assign stall      = stall_rs | stall_rt | stall_full;
  assign fire       = issue_valid && !stall;

`ifdef SB_TRACE_EN
  // trace each cycle an issue attempt is held back
  always_ff @(posedge clk) begin
    if (!reset && stall && issue_valid)
      $display("%d@stall rs=%d rt=%d", $time, rs_addr, rt_addr);
  end
`endif
endmodule

// File: tb/tb_d_reg_scoreboard.sv
// Directed bench for d_reg_scoreboard (CNT_W=2, TNEW_W=2).
module tb_d_reg_scoreboard;
  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] rs_addr, rt_addr, dst_addr, wb_addr;
  logic [1:0] rs_tuse, rt_tuse, dst_tnew;
  logic       rs_used, rt_used, dst_we, wb_we;
  logic       stall, stall_rs, stall_rt;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;

  d_reg_scoreboard #(.CNT_W(2), .TNEW_W(2)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
    .rs_used(rs_used), .rt_used(rt_used), .dst_we(dst_we), .dst_addr(dst_addr),
    .dst_tnew(dst_tnew), .wb_we(wb_we), .wb_addr(wb_addr),
    .stall(stall), .stall_rs(stall_rs), .stall_rt(stall_rt),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic idle();
    issue_valid = 0; rs_addr = 0; rt_addr = 0; rs_tuse = 0; rt_tuse = 0;
    rs_used = 0; rt_used = 0; dst_we = 0; dst_addr = 0; dst_tnew = 0;
    wb_we = 0; wb_addr = 0;
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue_wr(input logic [4:0] d, input logic [1:0] t);
    idle(); issue_valid = 1; dst_we = 1; dst_addr = d; dst_tnew = t;
  endtask

  task automatic test_reset();
    idle(); reset = 1; cyc(); reset = 0; #1;
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp %h", pending_mask, 32'h0); end
    checks++; if ({stall, stall_rs, stall_rt} !== 3'b000) begin errors++; $display("FAIL reset_stall got %b exp 000", {stall, stall_rs, stall_rt}); end
  endtask

  task automatic test_load_use();
    issue_wr(5'd8, 2'd2); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_issue stall got %b exp 0", stall); end
    cyc();
    // add $10 <- $8, needed in E
    issue_wr(5'd10, 2'd1); rs_used = 1; rs_addr = 8; rs_tuse = 1; #1;
    checks++; if ({stall, stall_rs} !== 2'b11) begin errors++; $display("FAIL lu_stall got %b exp 11", {stall, stall_rs}); end
    cyc(); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall); end
    cyc();
    idle(); #1;
    checks++; if (pending_mask !== 32'h0000_0500) begin errors++; $display("FAIL lu_mask got %h exp %h", pending_mask, 32'h0000_0500); end
    wb_we = 1; wb_addr = 8; cyc();
    checks++; if (pending_mask !== 32'h0000_0400) begin errors++; $display("FAIL lu_wb8 got %h exp %h", pending_mask, 32'h0000_0400); end
    wb_addr = 10; cyc(); idle();
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL lu_wb10 got %h exp 0", pending_mask); end
  endtask

  task automatic test_alu_branch();
    issue_wr(5'd9, 2'd1); cyc();
    idle(); issue_valid = 1; rs_used = 1; rs_addr = 9; rs_tuse = 0; #1;
    checks++; if ({stall, stall_rs, stall_rt} !== 3'b110) begin errors++; $display("FAIL br_stall got %b exp 110", {stall, stall_rs, stall_rt}); end
    cyc(); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_release got %b exp 0", stall); end
    cyc();
    issue_wr(5'd9, 2'd1); cyc();
    // same producer via rt with tuse 0 stalls on rt only
    idle(); issue_valid = 1; rt_used = 1; rt_addr = 9; rt_tuse = 0; #1;
    checks++; if ({stall, stall_rs, stall_rt} !== 3'b101) begin errors++; $display("FAIL br_rt got %b exp 101", {stall, stall_rs, stall_rt}); end
    idle(); issue_valid = 1; rs_used = 1; rs_addr = 9; rs_tuse = 1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_tuse1 got %b exp 0", stall); end
    idle(); wb_we = 1; wb_addr = 9; cyc(); cyc(); idle();
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL br_drain got %h exp 0", pending_mask); end
  endtask

  task automatic test_reg_zero();
    issue_wr(5'd0, 2'd2); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL z_issue got %b exp 0", stall); end
    cyc();
    idle(); issue_valid = 1; rs_used = 1; rt_used = 1; #1;
    checks++; if ({stall, pending_mask} !== 33'h0) begin errors++; $display("FAIL z_read stall %b mask %h exp 0", stall, pending_mask); end
    cyc(); idle();
  endtask

  task automatic test_full();
    for (int k = 0; k < 3; k++) begin issue_wr(5'd5, 2'd0); cyc(); end
    issue_wr(5'd5, 2'd0); #1;
    checks++; if ({stall, stall_rs, stall_rt, pending_mask[5]} !== 4'b1001) begin errors++; $display("FAIL full_stall got %b exp 1001", {stall, stall_rs, stall_rt, pending_mask[5]}); end
    wb_we = 1; wb_addr = 5; cyc(); wb_we = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_after_wb got %b exp 0", stall); end
    cyc(); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_refill got %b exp 1", stall); end
    idle(); wb_we = 1; wb_addr = 5;
    cyc(); cyc(); cyc(); idle();
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL full_drain got %h exp 0", pending_mask); end
  endtask

  task automatic test_same_cycle();
    issue_wr(5'd7, 2'd1); cyc();
    issue_wr(5'd7, 2'd2); wb_we = 1; wb_addr = 7; cyc();
    idle(); issue_valid = 1; rs_used = 1; rs_addr = 7; rs_tuse = 1; #1;
    checks++; if ({stall, pending_mask[7]} !== 2'b11) begin errors++; $display("FAIL sc_reload got %b exp 11", {stall, pending_mask[7]}); end
    idle(); wb_we = 1; wb_addr = 7; cyc(); idle();
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL sc_cnt1 got %h exp 0", pending_mask); end
    wb_we = 1; wb_addr = 10; cyc(); idle();
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL spur_mask got %h exp 0", pending_mask); end
    issue_wr(5'd10, 2'd0); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL spur_nowrap got %b exp 0", stall); end
    cyc(); idle(); wb_we = 1; wb_addr = 10; cyc(); idle();
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL spur_drain got %h exp 0", pending_mask); end
  endtask

  task automatic test_mid_reset();
    issue_wr(5'd3, 2'd2); cyc();
    issue_wr(5'd3, 2'd2); cyc(); idle(); #1;
    checks++; if (pending_mask !== 32'h0000_0008) begin errors++; $display("FAIL mr_pre got %h exp %h", pending_mask, 32'h8); end
    reset = 1; cyc(); reset = 0;
    issue_valid = 1; rs_used = 1; rs_addr = 3; rs_tuse = 0; #1;
    checks++; if ({stall, pending_mask} !== 33'h0) begin errors++; $display("FAIL mr_post stall %b mask %h exp 0", stall, pending_mask); end
    cyc(); idle();
  endtask

  initial begin
    idle(); reset = 1;
    cyc();
    test_reset();
    test_load_use();
    test_alu_branch();
    test_reg_zero();
    test_full();
    test_same_cycle();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
